// File: rtl/digififo_block_arbiter_if.sv
// rtl/digififo_block_arbiter_if.sv - DIGIFIFO / TEMPFIFO / converter signal bundle for the block arbiter
interface digififo_block_arbiter_if #(
  parameter int CNT_W = 17
);
  // control from the DDR write sequencer
  logic             run_en_i;
  logic             last_write_i;

  // DIGIFIFO side (FWFT heads and fill levels)
  logic [CNT_W-1:0] ch0_rdcnt_i;
  logic [CNT_W-1:0] ch1_rdcnt_i;
  logic [31:0]      ch0_data_i;
  logic [31:0]      ch1_data_i;
  logic             ch0_re_o;
  logic             ch1_re_o;

  // TEMPFIFO back-pressure
  logic             tempfifo_af_i;
  logic             tempfifo_empty_i;

  // converter side and status
  logic [31:0]      word_o;
  logic             word_valid_o;
  logic             grant_o;
  logic             busy_o;
  logic             block_done_o;
  logic [15:0]      ch0_blocks_o;
  logic [15:0]      ch1_blocks_o;

  // arbiter side
  modport slave (
    input  run_en_i, last_write_i,
    input  ch0_rdcnt_i, ch1_rdcnt_i, ch0_data_i, ch1_data_i,
    input  tempfifo_af_i, tempfifo_empty_i,
    output ch0_re_o, ch1_re_o,
    output word_o, word_valid_o, grant_o, busy_o, block_done_o,
    output ch0_blocks_o, ch1_blocks_o
  );

  // environment side
  modport master (
    output run_en_i, last_write_i,
    output ch0_rdcnt_i, ch1_rdcnt_i, ch0_data_i, ch1_data_i,
    output tempfifo_af_i, tempfifo_empty_i,
    input  ch0_re_o, ch1_re_o,
    input  word_o, word_valid_o, grant_o, busy_o, block_done_o,
    input  ch0_blocks_o, ch1_blocks_o
  );
endinterface

// File: rtl/digififo_block_arbiter.sv
// rtl/digififo_block_arbiter.sv - whole-block round-robin arbiter of two DIGIFIFOs onto the 32-to-64 converter (option: ARB_FIXED_PRIORITY_EN)
module digififo_block_arbiter #(
  parameter int BLOCK_WORDS = 256,
  parameter int CNT_W       = 17
) (
  input  logic                      digiclk_i,
  input  logic                      reset,
  digififo_block_arbiter_if.slave   bus
);

  localparam int               WCNT_W   = $clog2(BLOCK_WORDS) + 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(BLOCK_WORDS - 1);
  localparam logic [CNT_W:0]    BLK_THR   = (CNT_W+1)'(BLOCK_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_XFER = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic              armed;
  logic              hold;
  logic              stall;
  logic              elig0;
  logic              elig1;
  logic              sel_nxt;
  logic              grant_q;
  logic [WCNT_W-1:0] wcnt;
  logic              last_word;

  logic              re0;
  logic              re1;
  logic              busy;
  logic              grant_load;
  logic              last_beat;

  logic [31:0]       word_q;
  logic              valid_q;
  logic              done_q;
  logic [15:0]       blocks0_q;
  logic [15:0]       blocks1_q;

  // TEMPFIFO almost-full must cut the read in the same cycle, so stall
  // includes the raw input as well as the latched hold
  assign stall     = hold | bus.tempfifo_af_i;
  assign elig0     = {1'b0, bus.ch0_rdcnt_i} >= BLK_THR;
  assign elig1     = {1'b0, bus.ch1_rdcnt_i} >= BLK_THR;
  assign last_word = (wcnt == WCNT_LAST);

`ifdef ARB_FIXED_PRIORITY_EN
  // ch0 wins every tie; ch1 only when ch0 lacks a full block
  assign sel_nxt = ~elig0;
`else
  logic last_grant;

  // ties go to the channel not served last; only-one-eligible goes to that one
  assign sel_nxt = (elig0 & elig1) ? ~last_grant : elig1;

  // last grant starts at ch1 so ch0 takes the first tie after reset
  always_ff @(posedge digiclk_i or posedge reset) begin
    if (reset)
      last_grant <= 1'b1;
    else if (grant_load)
      last_grant <= sel_nxt;
  end
`endif

  // armed follows run_en/last_write; run_en has priority
  always_ff @(posedge digiclk_i or posedge reset) begin
    if (reset)
      armed <= 1'b0;
    else if (bus.run_en_i)
      armed <= 1'b1;
    else if (bus.last_write_i)
      armed <= 1'b0;
  end

  // hold latches almost-full until TEMPFIFO drains empty; af has priority
  always_ff @(posedge digiclk_i or posedge reset) begin
    if (reset)
      hold <= 1'b0;
    else if (bus.tempfifo_af_i)
      hold <= 1'b1;
    else if (bus.tempfifo_empty_i)
      hold <= 1'b0;
  end

  // FSM state register
  always_ff @(posedge digiclk_i or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // FSM next state: a started block always runs to completion
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (armed)
          state_nxt = S_ARB;
      end
      S_ARB: begin
        if (!armed)
          state_nxt = S_IDLE;
        else if (!stall && (elig0 || elig1))
          state_nxt = S_XFER;
      end
      S_XFER: begin
        if (!stall && last_word)
          state_nxt = S_ARB;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: reads only in XFER, only for the granted channel, only unstalled
  always_comb begin
    re0        = 1'b0;
    re1        = 1'b0;
    busy       = 1'b0;
    grant_load = 1'b0;
    last_beat  = 1'b0;
    case (state)
      S_ARB: begin
        grant_load = armed & ~stall & (elig0 | elig1);
      end
      S_XFER: begin
        busy      = 1'b1;
        re0       = ~grant_q & ~stall;
        re1       =  grant_q & ~stall;
        last_beat = ~stall & last_word;
      end
      default: ;
    endcase
  end

  // granted channel is held for the whole block, including across stalls
  always_ff @(posedge digiclk_i or posedge reset) begin
    if (reset)
      grant_q <= 1'b0;
    else if (grant_load)
      grant_q <= sel_nxt;
  end

  // word counter within the current block; frozen while stalled
  always_ff @(posedge digiclk_i or posedge reset) begin
    if (reset)
      wcnt <= '0;
    else if (last_beat)
      wcnt <= '0;
    else if (re0 || re1)
      wcnt <= wcnt + 1'b1;
  end

  // completed-block counters step on the edge that launches block_done
  always_ff @(posedge digiclk_i or posedge reset) begin
    if (reset) begin
      blocks0_q <= '0;
      blocks1_q <= '0;
    end else if (last_beat) begin
      if (grant_q)
        blocks1_q <= blocks1_q + 16'd1;
      else
        blocks0_q <= blocks0_q + 16'd1;
    end
  end

  // output word register: captures the FWFT head of the granted channel on each read
  always_ff @(posedge digiclk_i or posedge reset) begin
    if (reset) begin
      word_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= re0 | re1;
      done_q  <= last_beat;
      if (re0 || re1)
        word_q <= grant_q ? bus.ch1_data_i : bus.ch0_data_i;
    end
  end

  assign bus.ch0_re_o     = re0;
  assign bus.ch1_re_o     = re1;
  assign bus.busy_o       = busy;
  assign bus.grant_o      = grant_q;
  assign bus.word_o       = word_q;
  assign bus.word_valid_o = valid_q;
  assign bus.block_done_o = done_q;
  assign bus.ch0_blocks_o = blocks0_q;
  assign bus.ch1_blocks_o = blocks1_q;

endmodule

// File: tb/tb_digififo_block_arbiter.sv
// tb/tb_digififo_block_arbiter.sv - directed vector and sequence bench for digififo_block_arbiter
module tb_digififo_block_arbiter;

  localparam int BW = 256;

  logic digiclk_i = 1'b0;
  logic reset     = 1'b1;

  always #5 digiclk_i = ~digiclk_i;

  digififo_block_arbiter_if #(.CNT_W(17)) ifc ();

  digififo_block_arbiter #(.BLOCK_WORDS(BW), .CNT_W(17)) dut (
    .digiclk_i (digiclk_i),
    .reset     (reset),
    .bus       (ifc)
  );

  // FIFO model: each channel holds init words, head word = tag | read index
  int init0 = 0;
  int init1 = 0;
  int ptr0;
  int ptr1;

  always @(posedge digiclk_i or posedge reset) begin
    if (reset) begin
      ptr0 <= 0;
      ptr1 <= 0;
    end else begin
      if (ifc.ch0_re_o) ptr0 <= ptr0 + 1;
      if (ifc.ch1_re_o) ptr1 <= ptr1 + 1;
    end
  end

  assign ifc.ch0_rdcnt_i = 17'(init0 - ptr0);
  assign ifc.ch1_rdcnt_i = 17'(init1 - ptr1);
  assign ifc.ch0_data_i  = {4'hA, 28'(ptr0)};
  assign ifc.ch1_data_i  = {4'hB, 28'(ptr1)};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int  seen0, seen1, blk_words, blk_ch, viol, last_re_cyc;
  bit  pat_bad, re0_seen, prev_re;
  int  done_ch[$];
  int  done_words[$];
  int  gaps[$];

  typedef struct {
    int i0;
    int i1;
    bit af;
    bit busy;
    bit re0;
    bit re1;
    bit grant;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    seen0 = 0; seen1 = 0; blk_words = 0; blk_ch = 0; viol = 0;
    last_re_cyc = -1; pat_bad = 0; re0_seen = 0; prev_re = 0;
    done_ch.delete(); done_words.delete(); gaps.delete();
  endtask

  task automatic step();
    int ch;
    int idx;
    @(negedge digiclk_i);
    cyc++;
    if (ifc.ch0_re_o && ifc.ch1_re_o) viol++;
    if ((ifc.ch0_re_o || ifc.ch1_re_o) && !ifc.busy_o) viol++;
    if (ifc.ch0_re_o) re0_seen = 1;
    if (ifc.ch0_re_o || ifc.ch1_re_o) begin
      if (!prev_re && last_re_cyc >= 0) gaps.push_back(cyc - last_re_cyc);
      last_re_cyc = cyc;
      prev_re = 1;
    end else begin
      prev_re = 0;
    end
    if (ifc.word_valid_o) begin
      if (ifc.word_o[31:28] != 4'hA && ifc.word_o[31:28] != 4'hB) pat_bad = 1;
      ch  = (ifc.word_o[31:28] == 4'hB) ? 1 : 0;
      idx = int'(ifc.word_o[27:0]);
      if (idx != (ch == 1 ? seen1 : seen0)) pat_bad = 1;
      if (ch == 1) seen1++; else seen0++;
      blk_words++;
      if (blk_words == 1) blk_ch = ch;
      else if (ch != blk_ch) pat_bad = 1;
    end
    if (ifc.block_done_o) begin
      if (!ifc.word_valid_o) pat_bad = 1;
      done_ch.push_back(blk_ch);
      done_words.push_back(blk_words);
      blk_words = 0;
    end
  endtask

  task automatic do_reset();
    ifc.run_en_i         = 1'b0;
    ifc.last_write_i     = 1'b0;
    ifc.tempfifo_af_i    = 1'b0;
    ifc.tempfifo_empty_i = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    clear_mon();
  endtask

  task automatic arm();
    ifc.run_en_i = 1'b1;
    step();
    ifc.run_en_i = 1'b0;
    step();
    step();
  endtask

  task automatic run_blocks(input int n, input int budget);
    int k;
    k = 0;
    while (done_ch.size() < n && k < budget) begin
      step();
      k++;
    end
    chk("block_count", done_ch.size(), n);
  endtask

  task automatic wait_ptr(input int ch, input int n, input int budget);
    int k;
    k = 0;
    while (((ch == 0) ? ptr0 : ptr1) < n && k < budget) begin
      step();
      k++;
    end
    chk("wait_ptr_reached", ((ch == 0) ? ptr0 : ptr1) >= n, 1);
  endtask

  initial begin
    int exp_order[4];

    vt[0] = '{i0: 'h100,   i1: 'h100, af: 0, busy: 1, re0: 1, re1: 0, grant: 0};
    vt[1] = '{i0: 'hFF,    i1: 'h100, af: 0, busy: 1, re0: 0, re1: 1, grant: 1};
    vt[2] = '{i0: 'h100,   i1: 'hFF,  af: 0, busy: 1, re0: 1, re1: 0, grant: 0};
    vt[3] = '{i0: 'h100,   i1: 'h100, af: 0, busy: 1, re0: 1, re1: 0, grant: 0};
    vt[4] = '{i0: 'hFF,    i1: 'hFF,  af: 0, busy: 0, re0: 0, re1: 0, grant: 0};
    vt[5] = '{i0: 0,       i1: 'h200, af: 0, busy: 1, re0: 0, re1: 1, grant: 1};
    vt[6] = '{i0: 'h1FFFF, i1: 0,     af: 0, busy: 1, re0: 1, re1: 0, grant: 0};
    vt[7] = '{i0: 'h100,   i1: 'h100, af: 1, busy: 0, re0: 0, re1: 0, grant: 0};

`ifdef ARB_FIXED_PRIORITY_EN
    exp_order = '{0, 0, 1, 1};
`else
    exp_order = '{0, 1, 0, 1};
`endif

    // reset state
    ifc.run_en_i = 0; ifc.last_write_i = 0; ifc.tempfifo_af_i = 0; ifc.tempfifo_empty_i = 0;
    clear_mon();
    step();
    chk("rst_re0", ifc.ch0_re_o, 0);
    chk("rst_re1", ifc.ch1_re_o, 0);
    chk("rst_word", ifc.word_o, 0);
    chk("rst_valid", ifc.word_valid_o, 0);
    chk("rst_grant", ifc.grant_o, 0);
    chk("rst_busy", ifc.busy_o, 0);
    chk("rst_done", ifc.block_done_o, 0);
    chk("rst_blk0", ifc.ch0_blocks_o, 0);
    chk("rst_blk1", ifc.ch1_blocks_o, 0);

    // eligibility / first-grant vectors
    for (int v = 0; v < 8; v++) begin
      do_reset();
      init0 = vt[v].i0;
      init1 = vt[v].i1;
      ifc.tempfifo_af_i = vt[v].af;
      ifc.run_en_i = 1'b1;
      step();
      ifc.run_en_i = 1'b0;
      step();
      chk($sformatf("vec%0d_busy_early", v), ifc.busy_o, 0);
      step();
      chk($sformatf("vec%0d_busy", v), ifc.busy_o, vt[v].busy);
      chk($sformatf("vec%0d_re0", v), ifc.ch0_re_o, vt[v].re0);
      chk($sformatf("vec%0d_re1", v), ifc.ch1_re_o, vt[v].re1);
      chk($sformatf("vec%0d_grant", v), ifc.grant_o, vt[v].grant);
      ifc.tempfifo_af_i = 1'b0;
    end

    // four blocks from two channels holding two blocks each
    do_reset();
    init0 = 'h200; init1 = 'h200;
    arm();
    run_blocks(4, 1500);
    repeat (10) step();
    for (int i = 0; i < 4; i++) begin
      if (i < done_ch.size()) begin
        chk($sformatf("rr_order%0d", i), done_ch[i], exp_order[i]);
        chk($sformatf("rr_words%0d", i), done_words[i], BW);
      end
    end
    chk("rr_blk0", ifc.ch0_blocks_o, 2);
    chk("rr_blk1", ifc.ch1_blocks_o, 2);
    chk("rr_pattern_bad", pat_bad, 0);
    chk("rr_re_violations", viol, 0);
    chk("rr_idle_after", ifc.busy_o, 0);
    chk("rr_seen0", seen0, 512);
    chk("rr_gap_count", gaps.size(), 3);
    foreach (gaps[i]) chk($sformatf("rr_gap%0d", i), gaps[i], 2);

    // only ch1 eligible
    do_reset();
    init0 = 'hFF; init1 = 'h300;
    arm();
    run_blocks(3, 1200);
    repeat (10) step();
    foreach (done_ch[i]) chk($sformatf("ch1only_ch%0d", i), done_ch[i], 1);
    chk("ch1only_re0_seen", re0_seen, 0);
    chk("ch1only_blk1", ifc.ch1_blocks_o, 3);
    chk("ch1only_blk0", ifc.ch0_blocks_o, 0);
    chk("ch1only_seen1", seen1, 768);

    // almost-full at word 100
    do_reset();
    init0 = 'h100; init1 = 0;
    arm();
    wait_ptr(0, 100, 400);
    chk("af_pre_re", ifc.ch0_re_o, 1);
    ifc.tempfifo_af_i = 1'b1;
    #1;
    chk("af_same_cycle", ifc.ch0_re_o, 0);
    step();
    ifc.tempfifo_af_i = 1'b0;
    repeat (5) step();
    chk("hold_frozen", ptr0, 100);
    chk("hold_re_low", ifc.ch0_re_o, 0);
    chk("hold_busy", ifc.busy_o, 1);
    ifc.tempfifo_empty_i = 1'b1;
    #1;
    chk("empty_not_yet", ifc.ch0_re_o, 0);
    step();
    ifc.tempfifo_empty_i = 1'b0;
    chk("resume_re", ifc.ch0_re_o, 1);
    run_blocks(1, 400);
    repeat (5) step();
    if (done_words.size() > 0) chk("af_words", done_words[0], BW);
    chk("af_pattern_bad", pat_bad, 0);
    chk("af_blk0", ifc.ch0_blocks_o, 1);
    chk("af_seen0", seen0, BW);
    chk("af_re_violations", viol, 0);

    // last_write at word 50
    do_reset();
    init0 = 'h300; init1 = 'h300;
    arm();
    wait_ptr(0, 50, 300);
    ifc.last_write_i = 1'b1;
    step();
    ifc.last_write_i = 1'b0;
    run_blocks(1, 400);
    repeat (20) step();
    chk("lw_done_count", done_ch.size(), 1);
    if (done_words.size() > 0) chk("lw_words", done_words[0], BW);
    chk("lw_total_reads", ptr0 + ptr1, BW);
    chk("lw_busy", ifc.busy_o, 0);
    chk("lw_blk0", ifc.ch0_blocks_o, 1);
    chk("lw_blk1", ifc.ch1_blocks_o, 0);

    // reset mid-block at word 10 of a ch1 block
    do_reset();
    init0 = 'hFF; init1 = 'h200;
    arm();
    wait_ptr(1, 10, 300);
    reset = 1'b1;
    #1;
    chk("mrst_re1", ifc.ch1_re_o, 0);
    chk("mrst_busy", ifc.busy_o, 0);
    chk("mrst_valid", ifc.word_valid_o, 0);
    chk("mrst_word", ifc.word_o, 0);
    chk("mrst_done", ifc.block_done_o, 0);
    chk("mrst_grant", ifc.grant_o, 0);
    chk("mrst_blk1", ifc.ch1_blocks_o, 0);
    step();
    step();
    chk("mrst_no_done", done_ch.size(), 0);
    init0 = 'h200; init1 = 'h200;
    reset = 1'b0;
    clear_mon();
    arm();
    chk("mrst_rearm_grant", ifc.grant_o, 0);
    chk("mrst_rearm_re0", ifc.ch0_re_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
